// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-client RAM arbiter.
//   ADD_WIDTH_DEF / DATA_WIDTH_DEF : default RAM address / data widths
//   REQ0 / REQ1                    : requester ids used by the read tracker and pointer
package mem_arb_pkg;

    localparam int unsigned ADD_WIDTH_DEF  = 6;
    localparam int unsigned DATA_WIDTH_DEF = 4;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker.
//   i_elig  : eligible vector, bit k = client k may be granted this cycle
//   i_last  : id of the client granted most recently
//   o_win   : one-hot winner (all zero when nobody is eligible)
//   o_valid : a winner exists
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_elig,
    input  logic       i_last,
    output logic [1:0] o_win,
    output logic       o_valid
);

    always_comb begin
        o_win = 2'b00;
        unique case (i_elig)
            2'b01:   o_win = 2'b01;
            2'b10:   o_win = 2'b10;
            // Tie: the client that was not granted last goes next.
            2'b11:   o_win = (i_last == REQ0) ? 2'b10 : 2'b01;
            default: o_win = 2'b00;
        endcase
    end

    assign o_valid = |i_elig;

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two clients.
//   i_clk, i_rst_n                      : clock, synchronous active-low reset
//   i_req*/i_we*/i_addr*/i_wdata*       : client commands (held until granted)
//   o_gnt*                              : one-cycle grant pulse
//   o_rvalid*/o_rdata*                  : read return, rdata valid only with rvalid
//   o_mem_read/o_mem_wr/o_mem_address/o_mem_data_write : registered RAM command pins
//   i_mem_out                           : RAM registered read data
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADD_WIDTH  = ADD_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req0,
    input  logic                  i_req1,
    input  logic                  i_we0,
    input  logic                  i_we1,
    input  logic [ADD_WIDTH-1:0]  i_addr0,
    input  logic [ADD_WIDTH-1:0]  i_addr1,
    input  logic [DATA_WIDTH-1:0] i_wdata0,
    input  logic [DATA_WIDTH-1:0] i_wdata1,
    output logic                  o_gnt0,
    output logic                  o_gnt1,
    output logic                  o_rvalid0,
    output logic                  o_rvalid1,
    output logic [DATA_WIDTH-1:0] o_rdata0,
    output logic [DATA_WIDTH-1:0] o_rdata1,
    output logic                  o_mem_read,
    output logic                  o_mem_wr,
    output logic [ADD_WIDTH-1:0]  o_mem_address,
    output logic [DATA_WIDTH-1:0] o_mem_data_write,
    input  logic [DATA_WIDTH-1:0] i_mem_out
);

    logic [1:0]            r_gnt;
    logic [1:0]            r_rvalid;
    logic                  r_mem_read;
    logic                  r_mem_wr;
    logic [ADD_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_last;
    logic                  r_pend;
    logic                  r_pend_id;

    logic [1:0]            w_elig;
    logic [1:0]            w_win;
    logic                  w_valid;
    logic                  w_win_id;
    logic                  w_sel_we;
    logic [ADD_WIDTH-1:0]  w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    // A client whose grant is showing this cycle already had its command accepted.
    assign w_elig = {i_req1 & ~r_gnt[1], i_req0 & ~r_gnt[0]};

    rr_arb2 u_rr_arb2 (
        .i_elig  (w_elig),
        .i_last  (r_last),
        .o_win   (w_win),
        .o_valid (w_valid)
    );

    assign w_win_id    = w_win[1] ? REQ1 : REQ0;
    assign w_sel_we    = (w_win_id == REQ1) ? i_we1    : i_we0;
    assign w_sel_addr  = (w_win_id == REQ1) ? i_addr1  : i_addr0;
    assign w_sel_wdata = (w_win_id == REQ1) ? i_wdata1 : i_wdata0;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_gnt      <= 2'b00;
            r_rvalid   <= 2'b00;
            r_mem_read <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_last     <= REQ1;
            r_pend     <= 1'b0;
            r_pend_id  <= REQ0;
        end else begin
            r_gnt      <= w_win;
            r_mem_read <= w_valid & ~w_sel_we;
            r_mem_wr   <= w_valid & w_sel_we;
            // The RAM returns data one cycle after the read strobe, so rvalid
            // trails the pending flag by one cycle.
            r_rvalid   <= {r_pend & (r_pend_id == REQ1), r_pend & (r_pend_id == REQ0)};
            r_pend     <= w_valid & ~w_sel_we;
            if (w_valid) begin
                r_pend_id <= w_win_id;
                r_last    <= w_win_id;
                r_addr    <= w_sel_addr;
                r_wdata   <= w_sel_wdata;
            end
        end
    end

    assign o_gnt0           = r_gnt[0];
    assign o_gnt1           = r_gnt[1];
    assign o_rvalid0        = r_rvalid[0];
    assign o_rvalid1        = r_rvalid[1];
    assign o_rdata0         = i_mem_out;
    assign o_rdata1         = i_mem_out;
    assign o_mem_read       = r_mem_read;
    assign o_mem_wr         = r_mem_wr;
    assign o_mem_address    = r_addr;
    assign o_mem_data_write = r_wdata;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
module tb_mem_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] we;
    logic [5:0] addr [2];
    logic [3:0] wdata [2];

    logic       gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_wr;
    logic [3:0] rdata0, rdata1, mem_data_write;
    logic [5:0] mem_address;
    logic [3:0] mem_out = 4'h0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_rr_arbiter #(.ADD_WIDTH(6), .DATA_WIDTH(4)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_req0           (req[0]),
        .i_req1           (req[1]),
        .i_we0            (we[0]),
        .i_we1            (we[1]),
        .i_addr0          (addr[0]),
        .i_addr1          (addr[1]),
        .i_wdata0         (wdata[0]),
        .i_wdata1         (wdata[1]),
        .o_gnt0           (gnt0),
        .o_gnt1           (gnt1),
        .o_rvalid0        (rvalid0),
        .o_rvalid1        (rvalid1),
        .o_rdata0         (rdata0),
        .o_rdata1         (rdata1),
        .o_mem_read       (mem_read),
        .o_mem_wr         (mem_wr),
        .o_mem_address    (mem_address),
        .o_mem_data_write (mem_data_write),
        .i_mem_out        (mem_out)
    );

    // Single-port synchronous RAM, registered read, read has priority.
    logic [3:0] ram [64] = '{default: 4'h0};
    always @(posedge clk) begin
        if (mem_read) mem_out <= ram[mem_address];
        else if (mem_wr) ram[mem_address] <= mem_data_write;
    end

    // Reference model: transaction-level view. Accesses take effect in grant
    // order on ref_mem; a read's data is known at grant and returned a cycle later.
    logic [3:0] ref_mem [64] = '{default: 4'h0};
    int         m_last  = 1;
    int         m_rd_id = -1;
    logic [3:0] m_rd_data;
    logic [1:0] e_gnt   = 2'b00;
    logic [1:0] e_rvalid = 2'b00;
    logic       e_read  = 1'b0;
    logic       e_wr    = 1'b0;
    logic [5:0] e_addr  = 6'd0;
    logic [3:0] e_wdata = 4'h0;
    logic [3:0] e_rdata = 4'h0;

    task automatic tick();
        int  win;
        bit  el0, el1;
        if (!rst_n) begin
            e_gnt = 2'b00; e_rvalid = 2'b00; e_read = 1'b0; e_wr = 1'b0;
            e_addr = 6'd0; e_wdata = 4'h0; m_last = 1; m_rd_id = -1;
        end else begin
            e_rvalid = 2'b00;
            if (m_rd_id >= 0) begin
                e_rvalid[m_rd_id] = 1'b1;
                e_rdata = m_rd_data;
            end
            m_rd_id = -1;
            el0 = req[0] && !e_gnt[0];
            el1 = req[1] && !e_gnt[1];
            win = -1;
            if (el0 && el1) win = 1 - m_last;
            else if (el0)   win = 0;
            else if (el1)   win = 1;
            e_gnt = 2'b00; e_read = 1'b0; e_wr = 1'b0;
            if (win >= 0) begin
                e_gnt[win] = 1'b1;
                m_last  = win;
                e_addr  = addr[win];
                e_wdata = wdata[win];
                if (we[win]) begin
                    e_wr = 1'b1;
                    ref_mem[addr[win]] = wdata[win];
                end else begin
                    e_read    = 1'b1;
                    m_rd_id   = win;
                    m_rd_data = ref_mem[addr[win]];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = 2'b00;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 2'b11; we = 2'b00; addr[0] = 6'd0; addr[1] = 6'd1;
        wdata[0] = 4'h0; wdata[1] = 4'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_wr, mem_address, mem_data_write}
                !== 16'h0) begin
                bad++;
                $display("FAIL reset_outputs cyc=%0d got gnt=%b%b rv=%b%b rd=%b wr=%b a=%0h d=%0h exp all 0",
                         i, gnt1, gnt0, rvalid1, rvalid0, mem_read, mem_wr, mem_address,
                         mem_data_write);
            end
        end
        rst_n = 1'b1;
        tick();
        total++;
        if ({gnt1, gnt0} !== 2'b01) begin
            bad++;
            $display("FAIL reset_first_grant got %b%b exp 01", gnt1, gnt0);
        end
        idle(2);
    endtask

    task automatic test_write_read();
        req = 2'b01; we[0] = 1'b1; addr[0] = 6'd5; wdata[0] = 4'hA;
        tick();
        total++;
        if ({gnt0, gnt1, mem_wr, mem_read, mem_address, mem_data_write} !== {4'b1010, 6'd5, 4'hA}) begin
            bad++;
            $display("FAIL wr_cmd got g0=%b g1=%b wr=%b rd=%b a=%0d d=%0h exp 1 0 1 0 5 a",
                     gnt0, gnt1, mem_wr, mem_read, mem_address, mem_data_write);
        end
        idle(1);
        req = 2'b01; we[0] = 1'b0; addr[0] = 6'd5;
        tick();
        total++;
        if ({gnt0, mem_read, mem_wr} !== 3'b110) begin
            bad++;
            $display("FAIL rd_cmd got g0=%b rd=%b wr=%b exp 1 1 0", gnt0, mem_read, mem_wr);
        end
        req = 2'b00;
        tick();
        total++;
        if ({rvalid0, rvalid1, rdata0} !== {2'b10, 4'hA}) begin
            bad++;
            $display("FAIL rd_return got rv0=%b rv1=%b rdata0=%0h exp 1 0 a",
                     rvalid0, rvalid1, rdata0);
        end
        idle(2);
    endtask

    task automatic test_contention();
        logic prev_g0;
        req = 2'b11; we = 2'b00; addr[0] = 6'd16; addr[1] = 6'd32;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if ({gnt1, gnt0} !== e_gnt || (gnt0 ^ gnt1) !== 1'b1 || mem_read !== 1'b1) begin
                bad++;
                $display("FAIL contention_grant cyc=%0d got gnt=%b%b rd=%b exp gnt=%b rd=1",
                         i, gnt1, gnt0, mem_read, e_gnt);
            end
            if (i > 0) begin
                total++;
                if (gnt0 === prev_g0) begin
                    bad++;
                    $display("FAIL contention_alternate cyc=%0d got g0=%b exp %b", i, gnt0, ~prev_g0);
                end
            end
            prev_g0 = gnt0;
            total++;
            if ({rvalid1, rvalid0} !== e_rvalid) begin
                bad++;
                $display("FAIL contention_rvalid cyc=%0d got %b%b exp %b", i, rvalid1, rvalid0, e_rvalid);
            end
        end
        idle(2);
    endtask

    task automatic test_cross_clients();
        req = 2'b01; we[0] = 1'b0; addr[0] = 6'd1;
        tick();
        idle(2);
        req = 2'b11; we = 2'b10; addr[0] = 6'd63; addr[1] = 6'd63; wdata[1] = 4'h3;
        tick();
        total++;
        if ({gnt1, gnt0, mem_wr, mem_address} !== {3'b101, 6'd63}) begin
            bad++;
            $display("FAIL cross_write_first got g1=%b g0=%b wr=%b a=%0d exp 1 0 1 63",
                     gnt1, gnt0, mem_wr, mem_address);
        end
        req = 2'b01;
        tick();
        total++;
        if ({gnt0, mem_read} !== 2'b11) begin
            bad++;
            $display("FAIL cross_read_second got g0=%b rd=%b exp 1 1", gnt0, mem_read);
        end
        req = 2'b00;
        tick();
        total++;
        if ({rvalid0, rdata0} !== {1'b1, 4'h3}) begin
            bad++;
            $display("FAIL cross_read_data got rv0=%b rdata0=%0h exp 1 3", rvalid0, rdata0);
        end
        idle(2);
    endtask

    task automatic test_reset_mid_read();
        req = 2'b01; we[0] = 1'b0; addr[0] = 6'd63;
        tick();
        total++;
        if (mem_read !== 1'b1) begin
            bad++;
            $display("FAIL midrst_read got rd=%b exp 1", mem_read);
        end
        rst_n = 1'b0; req = 2'b00;
        tick();
        total++;
        if ({gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_wr, mem_address, mem_data_write}
            !== 16'h0) begin
            bad++;
            $display("FAIL midrst_outputs got gnt=%b%b rv=%b%b rd=%b wr=%b a=%0h d=%0h exp all 0",
                     gnt1, gnt0, rvalid1, rvalid0, mem_read, mem_wr, mem_address, mem_data_write);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if ({rvalid1, rvalid0} !== 2'b00) begin
            bad++;
            $display("FAIL midrst_no_rvalid got %b%b exp 00", rvalid1, rvalid0);
        end
    endtask

    task automatic test_single_rate();
        req = 2'b10; we[1] = 1'b0; addr[1] = 6'd7;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (gnt1 !== ((i % 2) == 0) || gnt0 !== 1'b0) begin
                bad++;
                $display("FAIL single_rate cyc=%0d got g1=%b g0=%b exp %0d 0", i, gnt1, gnt0,
                         ((i % 2) == 0));
            end
            total++;
            if ((mem_read & mem_wr) !== 1'b0) begin
                bad++;
                $display("FAIL single_excl cyc=%0d got rd=%b wr=%b", i, mem_read, mem_wr);
            end
        end
        idle(2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (!req[k] || e_gnt[k]) begin
                    req[k]   = ($urandom_range(0, 9) < 7);
                    we[k]    = 1'($urandom_range(0, 1));
                    addr[k]  = 6'($urandom_range(0, 3));
                    wdata[k] = 4'($urandom_range(0, 15));
                end
            end
            tick();
            total++;
            if ({gnt1, gnt0} !== e_gnt || mem_read !== e_read || mem_wr !== e_wr ||
                mem_address !== e_addr || mem_data_write !== e_wdata) begin
                bad++;
                $display("FAIL rand_cmd cyc=%0d got g=%b rd=%b wr=%b a=%0h d=%0h exp g=%b rd=%b wr=%b a=%0h d=%0h",
                         i, {gnt1, gnt0}, mem_read, mem_wr, mem_address, mem_data_write,
                         e_gnt, e_read, e_wr, e_addr, e_wdata);
            end
            total++;
            if ({rvalid1, rvalid0} !== e_rvalid ||
                (e_rvalid[0] && rdata0 !== e_rdata) || (e_rvalid[1] && rdata1 !== e_rdata)) begin
                bad++;
                $display("FAIL rand_read cyc=%0d got rv=%b%b rd0=%0h rd1=%0h exp rv=%b data=%0h",
                         i, rvalid1, rvalid0, rdata0, rdata1, e_rvalid, e_rdata);
            end
            total++;
            if ((mem_read & mem_wr) !== 1'b0) begin
                bad++;
                $display("FAIL rand_excl cyc=%0d got rd=%b wr=%b", i, mem_read, mem_wr);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req = 2'b00; we = 2'b00;
        addr[0] = 6'd0; addr[1] = 6'd0; wdata[0] = 4'h0; wdata[1] = 4'h0;
        test_reset();
        test_write_read();
        test_contention();
        test_cross_clients();
        test_reset_mid_read();
        test_single_rate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_rr_arbiter.md
# mem_rr_arbiter

Two-requester round-robin arbiter that shares one single-port synchronous RAM (read has priority over write, registered read data, one-cycle read latency) between two independent clients. It registers the winning command onto the RAM control pins, issues a one-cycle grant, and routes the returned read data to the originating requester with a valid strobe. It sits directly in front of the RAM, and the RAM pins are driven only by this block.

## Interface
- ADD_WIDTH, 6, RAM address width
- DATA_WIDTH, 4, RAM data width
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req0 / req1  in  1  request from client 0 / client 1
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADD_WIDTH  access address
- wdata0 / wdata1  in  DATA_WIDTH  write data
- gnt0 / gnt1  out  1  one-cycle grant pulse; command accepted
- rvalid0 / rvalid1  out  1  one-cycle read-data-valid pulse
- rdata0 / rdata1  out  DATA_WIDTH  read data; meaningful only while the matching rvalid is high
- mem_read  out  1  RAM read strobe
- mem_wr  out  1  RAM write strobe
- mem_address  out  ADD_WIDTH  RAM address
- mem_data_write  out  DATA_WIDTH  RAM write data
- mem_out  in  DATA_WIDTH  RAM registered read data

## Operation
- **Eligibility:** client k is eligible in a cycle when reqk=1 and gntk=0 in that cycle. A client is never re-granted in the cycle its grant is high.
- **Arbitration** at each rising edge:
  - One client eligible: that client wins.
  - Both eligible: the client that was not granted last wins.
  - The last-grant pointer updates only on a grant.
- **Client rules:** hold req/we/addr/wdata stable from assertion through the cycle gnt is high, inclusive. In the next cycle the client may drop req or present a new command.
- **Command register:** on a win, register mem_read = ~we, mem_wr = we, mem_address = addr, mem_data_write = wdata, and gnt of the winner = 1. With no winner, mem_read = mem_wr = 0, and address/data hold their previous values.
- **mem_read and mem_wr** are never high together.
- **Read tracking:** a read grant sets a pending flag plus a 1-bit requester id. In the following cycle, assert rvalid of that id. rdata0 and rdata1 are both continuously driven from mem_out.
- **Ordering:** accesses execute in grant order. A read granted after a write to the same address, by either client, returns the new data.
- **Throughput:** one RAM access per cycle when the two clients alternate. A single client alone gets one access every 2 cycles.

## Timing
- **Reset** (rst_n low at an edge): gnt0 = gnt1 = 0, rvalid0 = rvalid1 = 0, mem_read = mem_wr = 0, mem_address = 0, mem_data_write = 0, pending flag cleared, last-grant pointer = client 1 (so client 0 wins the first tie).
- **Reset mid-operation:** any outstanding read is discarded; no rvalid follows it.
- **Read, sampled at edge ending cycle N:**
  - cycle N+1: gnt and mem_read high.
  - cycle N+2: rvalid high, rdata = mem_out.
  - Latency from request to data: 2 cycles.
- **Write, sampled at edge ending cycle N:**
  - cycle N+1: gnt and mem_wr high.
  - RAM array updated at the edge ending N+1.
- **Overlap:** a read grant in N+1 and its rvalid in N+2 may coincide with another grant in N+2. This is legal and needs no stall.
- **Corner cases:**
  - Both clients requesting forever: strict alternation 0,1,0,1…
  - Both requesting the same address, one read and one write: order is set by the pointer only.
  - Address wrap-around is the RAM's concern; the arbiter passes the address unmodified.

## Structure
- **Shared package mem_arb_pkg:**
  - default ADD_WIDTH / DATA_WIDTH constants
  - requester-id constants (REQ0 = 1'b0, REQ1 = 1'b1)
- **Sub-module rr_arb2:** combinational two-way round-robin picker.
  - Inputs: eligible vector, last-grant pointer.
  - Outputs: one-hot winner, valid.
- **Top level:** owns the command register, pointer register, pending read flag/id, and the RAM-facing outputs.

## Test plan
- **Reset:** hold rst_n = 0 for 3 cycles with req0 = req1 = 1 → all outputs 0; first grant after release is gnt0.
- **Write/read one client:** client 0 writes addr 5, data 4'hA; then reads addr 5 → gnt0 is 1 cycle after req; rvalid0 is 2 cycles after the read req, with rdata0 = 4'hA; rvalid1 stays 0.
- **Contention:** req0 and req1 held high for 8 cycles, all reads → grants alternate 0,1,0,1…; mem_read high every cycle from cycle 1; each rvalid lands on the correct client 1 cycle after its grant.
- **Write-then-read across clients:** client 1 writes addr 63, data 4'h3 while client 0 reads addr 63 in the same cycle, pointer favouring client 1 → write granted first; client 0 then receives 4'h3.
- **Reset mid-read:** assert rst_n = 0 in the cycle mem_read is high → no rvalid follows; outputs are at reset values the next cycle.
- **Single requester rate:** req1 held high for 6 cycles → gnt1 high every other cycle; mem_read and mem_wr are never both 1.
